mix_scheduler: RTL and testbench

MIX_SCHEDULER -- requirements
Module: mix_scheduler

---
 rtl/mix_pkg.sv | 15 +
 rtl/mix_reduce.sv | 41 ++++
 rtl/mix_scheduler.sv | 179 +++++++++++++++++
 tb/tb_mix_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the channel mixer: scheduler state encoding,
// default channel count and sample width, and the underrun counter width.
package mix_pkg;

    localparam int MIX_N_CH_DEF = 4;
    localparam int MIX_BITS_DEF = 24;
    localparam int UNDERRUN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_HOLD   = 2'd2
    } mix_state_e;

endpackage

// File: rtl/mix_reduce.sv
// Combinational reduction of a wide signed accumulator to one output sample.
// Build option MIX_SATURATE_EN: when defined, out-of-range sums clamp to the
// most positive / most negative sample; otherwise the low OUT_W bits are kept
// (two's complement wrap).
module mix_reduce
    import mix_pkg::*;
#(
    parameter int IN_W  = 26,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  acc,
    output logic [OUT_W-1:0] sample
);

`ifdef MIX_SATURATE_EN
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = acc[IN_W-1:OUT_W-1];

    // Clamp toward the accumulator's sign when the upper bits disagree.
    always_comb begin
        sample = acc[OUT_W-1:0];
        if (!(&top_bits) && (|top_bits)) begin
            sample = acc[IN_W-1] ? NEG_MIN : POS_MAX;
        end
    end
`else
    // Guard bits are deliberately discarded in wrap mode.
    logic unused_hi;
    assign unused_hi = ^acc[IN_W-1:OUT_W];

    // Wrap: keep the low sample bits only.
    always_comb begin
        sample = acc[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/mix_scheduler.sv
// Time-multiplexed stereo mixer feeding an I2S transmitter.
// One channel is visited per cycle (GATHER), the summed frame is then offered
// on l_data/r_data with data_en until the transmitter pulses data_entered.
// Build option MIX_SATURATE_EN selects saturating instead of wrapping
// reduction of the accumulators (see mix_reduce).
//
// Handshakes: on the source side ch_ready[i] is a single-cycle pulse in the
// slot cycle of channel i whenever ch_valid[i] is high (muted samples are
// drained too); the source must hold data/valid stable until that pulse.
// On the sink side data_en plays valid and data_entered plays ready: the frame
// is transferred in a cycle where both are high, and l_data/r_data/data_en do
// not change while waiting for it.
module mix_scheduler
    import mix_pkg::*;
#(
    parameter int N_CH           = MIX_N_CH_DEF,
    parameter int BITS_PRECISION = MIX_BITS_DEF
) (
    input  logic                           sck,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [N_CH*BITS_PRECISION-1:0] ch_l_data,
    input  logic [N_CH*BITS_PRECISION-1:0] ch_r_data,
    input  logic [N_CH-1:0]                ch_valid,
    input  logic [N_CH-1:0]                ch_mute,
    output logic [N_CH-1:0]                ch_ready,
    output logic [BITS_PRECISION-1:0]      l_data,
    output logic [BITS_PRECISION-1:0]      r_data,
    output logic                           data_en,
    input  logic                           data_entered,
    output logic [UNDERRUN_W-1:0]          underrun_cnt,
    output logic [1:0]                     state_dbg
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int ACC_W = BITS_PRECISION + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    mix_state_e state;
    mix_state_e state_next;

    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc_l;
    logic signed [ACC_W-1:0]   acc_r;
    logic [BITS_PRECISION-1:0] samp_l;
    logic [BITS_PRECISION-1:0] samp_r;
    logic                      slot_valid;
    logic                      slot_mute;
    logic                      take;
    logic                      hole;
    logic signed [ACC_W-1:0]   add_l;
    logic signed [ACC_W-1:0]   add_r;
    logic signed [ACC_W-1:0]   sum_l;
    logic signed [ACC_W-1:0]   sum_r;
    logic [BITS_PRECISION-1:0] red_l;
    logic [BITS_PRECISION-1:0] red_r;

    assign state_dbg = state;

    // Decode the current slot: select its samples and classify it as
    // mixed, drained (muted) or missing.
    always_comb begin
        samp_l     = ch_l_data[int'(idx)*BITS_PRECISION +: BITS_PRECISION];
        samp_r     = ch_r_data[int'(idx)*BITS_PRECISION +: BITS_PRECISION];
        slot_valid = ch_valid[idx];
        slot_mute  = ch_mute[idx];
        take       = (state == ST_GATHER) && slot_valid && !slot_mute;
        hole       = (state == ST_GATHER) && !slot_valid && !slot_mute;
        add_l      = '0;
        add_r      = '0;
        if (take) begin
            add_l = {{IDX_W{samp_l[BITS_PRECISION-1]}}, samp_l};
            add_r = {{IDX_W{samp_r[BITS_PRECISION-1]}}, samp_r};
        end
        sum_l = acc_l + add_l;
        sum_r = acc_r + add_r;
    end

    // Reduce the running sums (including the current slot) to output width.
    mix_reduce #(.IN_W(ACC_W), .OUT_W(BITS_PRECISION)) u_reduce_l (
        .acc    (sum_l),
        .sample (red_l)
    );

    mix_reduce #(.IN_W(ACC_W), .OUT_W(BITS_PRECISION)) u_reduce_r (
        .acc    (sum_r),
        .sample (red_r)
    );

    // State register.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the source-side ready pulse.
    always_comb begin
        state_next = state;
        ch_ready   = '0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (slot_valid) begin
                    ch_ready[idx] = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (data_entered) begin
                    state_next = run ? ST_GATHER : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Slot index, accumulators, output frame and underrun counter.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            l_data       <= '0;
            r_data       <= '0;
            data_en      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx   <= '0;
                    acc_l <= '0;
                    acc_r <= '0;
                end
                ST_GATHER: begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    if (hole && (underrun_cnt != {UNDERRUN_W{1'b1}})) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        l_data  <= red_l;
                        r_data  <= red_r;
                        data_en <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (data_entered) begin
                        idx   <= '0;
                        acc_l <= '0;
                        acc_r <= '0;
                        if (!run) begin
                            data_en <= 1'b0;
                            l_data  <= '0;
                            r_data  <= '0;
                        end
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler (N_CH=4, 24-bit samples).
module tb_mix_scheduler;

    localparam int N = 4;
    localparam int B = 24;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

`ifdef MIX_SATURATE_EN
    localparam logic [B-1:0] EXT_L = 24'h7FFFFF;
    localparam logic [B-1:0] EXT_R = 24'h800000;
`else
    localparam logic [B-1:0] EXT_L = 24'hFFFFFC;
    localparam logic [B-1:0] EXT_R = 24'h000000;
`endif

    logic           sck = 1'b0;
    logic           rst_n;
    logic           run;
    logic [N*B-1:0] ch_l_data;
    logic [N*B-1:0] ch_r_data;
    logic [N-1:0]   ch_valid;
    logic [N-1:0]   ch_mute;
    logic [N-1:0]   ch_ready;
    logic [B-1:0]   l_data;
    logic [B-1:0]   r_data;
    logic           data_en;
    logic           data_entered;
    logic [15:0]    underrun_cnt;
    logic [1:0]     state_dbg;

    int n_checks = 0;
    int n_bad    = 0;
    logic [2*B-1:0] exp_q[$];

    mix_scheduler #(.N_CH(N), .BITS_PRECISION(B)) dut (
        .sck          (sck),
        .rst_n        (rst_n),
        .run          (run),
        .ch_l_data    (ch_l_data),
        .ch_r_data    (ch_r_data),
        .ch_valid     (ch_valid),
        .ch_mute      (ch_mute),
        .ch_ready     (ch_ready),
        .l_data       (l_data),
        .r_data       (r_data),
        .data_en      (data_en),
        .data_entered (data_entered),
        .underrun_cnt (underrun_cnt),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    always #5 sck = ~sck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checker
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic set_ch(input int i, input logic [B-1:0] l, input logic [B-1:0] r);
        ch_l_data[i*B +: B] = l;
        ch_r_data[i*B +: B] = r;
    endtask

    task automatic step();
        @(posedge sck);
        #1;
    endtask

    task automatic pulse_entered();
        data_entered = 1'b1;
        step();
        data_entered = 1'b0;
    endtask

    task automatic expect_frame(input logic [B-1:0] l, input logic [B-1:0] r);
        exp_q.push_back({l, r});
    endtask

    // Walks the four slots of a gather already entered, then checks the
    // loaded frame against the scoreboard head.
    task automatic gather_frame(input logic [15:0] rdy_seq, input logic en_before,
                                input logic [B-1:0] hold_l, input int drop_at,
                                input string tag);
        logic [2*B-1:0] e;
        for (int k = 0; k < N; k++) begin
            @(negedge sck);
            check_eq({tag, "_rdy"}, 64'(ch_ready), 64'(rdy_seq[k*4 +: 4]));
            check_eq({tag, "_state"}, 64'(state_dbg), 64'(S_GATHER));
            check_eq({tag, "_en_hold"}, 64'(data_en), 64'(en_before));
            check_eq({tag, "_l_hold"}, 64'(l_data), 64'(hold_l));
            if (k == drop_at) run = 1'b0;
            step();
        end
        @(negedge sck);
        check_eq({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_l"}, 64'(l_data), 64'(e[2*B-1:B]));
            check_eq({tag, "_r"}, 64'(r_data), 64'(e[B-1:0]));
        end
        check_eq({tag, "_en"}, 64'(data_en), 64'd1);
        check_eq({tag, "_hold_state"}, 64'(state_dbg), 64'(S_HOLD));
        check_eq({tag, "_rdy_off"}, 64'(ch_ready), 64'd0);
    endtask

    // Stimulus
    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        data_entered = 1'b0;
        ch_l_data    = '0;
        ch_r_data    = '0;
        ch_valid     = '0;
        ch_mute      = '0;

        // Reset state
        repeat (2) @(negedge sck);
        check_eq("rst_l", 64'(l_data), 64'd0);
        check_eq("rst_r", 64'(r_data), 64'd0);
        check_eq("rst_en", 64'(data_en), 64'd0);
        check_eq("rst_rdy", 64'(ch_ready), 64'd0);
        check_eq("rst_under", 64'(underrun_cnt), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'(S_IDLE));
        rst_n = 1'b1;

        // Frame 1: all valid, L 1..4 -> 10, R -1,-2,5,100 -> 102
        set_ch(0, 24'd1, 24'hFFFFFF);
        set_ch(1, 24'd2, 24'hFFFFFE);
        set_ch(2, 24'd3, 24'd5);
        set_ch(3, 24'd4, 24'd100);
        ch_valid = 4'b1111;
        ch_mute  = 4'b0000;
        @(negedge sck);
        check_eq("idle_wait", 64'(state_dbg), 64'(S_IDLE));
        expect_frame(24'd10, 24'd102);
        run = 1'b1;
        step();
        gather_frame(16'h8421, 1'b0, 24'd0, -1, "f1");
        check_eq("f1_under", 64'(underrun_cnt), 64'd0);

        // Frame 2: channel 2 missing -> one underrun, 100+200+300, 1+1+1
        set_ch(0, 24'd100, 24'd1);
        set_ch(1, 24'd200, 24'd1);
        set_ch(2, 24'd9999, 24'd7);
        set_ch(3, 24'd300, 24'd1);
        ch_valid = 4'b1011;
        expect_frame(24'd600, 24'd3);
        pulse_entered();
        gather_frame(16'h8021, 1'b1, 24'd10, -1, "f2");
        check_eq("f2_under", 64'(underrun_cnt), 64'd1);

        // Frame 3: ch1 muted+valid (drained), ch2 muted+invalid (silent)
        set_ch(0, 24'd5, 24'd4);
        set_ch(1, 24'd1000, 24'd4);
        set_ch(2, 24'd777, 24'd4);
        set_ch(3, 24'hFFFFFD, 24'd4);
        ch_valid = 4'b1011;
        ch_mute  = 4'b0110;
        expect_frame(24'd2, 24'd8);
        pulse_entered();
        gather_frame(16'h8021, 1'b1, 24'd600, -1, "f3");
        check_eq("f3_under", 64'(underrun_cnt), 64'd1);

        // Frame 4: full-scale positive on L, full-scale negative on R
        for (int i = 0; i < N; i++) set_ch(i, 24'h7FFFFF, 24'h800000);
        ch_valid = 4'b1111;
        ch_mute  = 4'b0000;
        expect_frame(EXT_L, EXT_R);
        pulse_entered();
        gather_frame(16'h8421, 1'b1, 24'd2, -1, "f4");

        // Long hold without data_entered: frame and handshake frozen
        for (int c = 0; c < 100; c++) begin
            @(negedge sck);
            check_eq("hold100", {9'd0, state_dbg, data_en, ch_ready, l_data, r_data},
                     {9'd0, S_HOLD, 1'b1, 4'b0000, EXT_L, EXT_R});
        end

        // run low in HOLD without data_entered: stays in HOLD
        run = 1'b0;
        repeat (3) begin
            @(negedge sck);
            check_eq("hold_norun", 64'(state_dbg), 64'(S_HOLD));
        end

        // Frame 5: run dropped after slot 1, frame still completes
        run = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 24'd1, 24'd2);
        expect_frame(24'd4, 24'd8);
        pulse_entered();
        gather_frame(16'h8421, 1'b1, EXT_L, 1, "f5");
        repeat (3) begin
            @(negedge sck);
            check_eq("f5_hold", {state_dbg, data_en, l_data}, {S_HOLD, 1'b1, 24'd4});
        end
        pulse_entered();
        @(negedge sck);
        check_eq("stop_state", 64'(state_dbg), 64'(S_IDLE));
        check_eq("stop_en", 64'(data_en), 64'd0);
        check_eq("stop_l", 64'(l_data), 64'd0);
        check_eq("stop_r", 64'(r_data), 64'd0);
        check_eq("stop_under", 64'(underrun_cnt), 64'd1);

        // data_entered in IDLE is ignored
        pulse_entered();
        @(negedge sck);
        check_eq("idle_de_state", 64'(state_dbg), 64'(S_IDLE));
        check_eq("idle_de_en", 64'(data_en), 64'd0);
        check_eq("idle_de_under", 64'(underrun_cnt), 64'd1);

        // Reset asserted in slot 2 of a gather
        for (int i = 0; i < N; i++) set_ch(i, 24'(i + 1), 24'(10 * (i + 1)));
        run = 1'b1;
        step();
        step();
        step();
        @(negedge sck);
        check_eq("pre_rst_rdy", 64'(ch_ready), 64'b0100);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {9'd0, state_dbg, data_en, ch_ready, underrun_cnt, l_data[7:0]},
                 {9'd0, S_IDLE, 1'b0, 4'b0000, 16'd0, 8'd0});
        check_eq("async_rst_lr", {16'd0, l_data, r_data}, 64'd0);
        #2;
        rst_n = 1'b1;
        expect_frame(24'd10, 24'd100);
        step();
        gather_frame(16'h8421, 1'b0, 24'd0, -1, "f6");
        check_eq("f6_under", 64'(underrun_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
